// File: rtl/nw_pkg.sv
// Shared definitions for the NW A/B sequence-RAM index generator.
//   nw_idx_state_t : index generator controller states
//   TB_*           : traceback move encoding (bit 1 = i-1, bit 0 = j-1)
//   IDX_SAFE       : reserved harmless RAM address driven when idle
package nw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_FILL_DONE,
    ST_TRACE,
    ST_END
  } nw_idx_state_t;

  localparam logic [1:0] TB_NONE = 2'b00;
  localparam logic [1:0] TB_LEFT = 2'b01;
  localparam logic [1:0] TB_UP   = 2'b10;
  localparam logic [1:0] TB_DIAG = 2'b11;

  localparam int unsigned IDX_SAFE = 0;

endpackage

// File: rtl/nw_idx_counter.sv
// One sequence-RAM address counter (used for both i and j).
//   clk, rst_n       : clock, asynchronous active-low reset (clears to IDX_SAFE)
//   load, load_val   : load a value (highest priority)
//   inc              : increment, wrapping N -> 1
//   dec              : decrement, saturating at 0
//   cnt              : current count
//   cnt_next         : value the counter takes at the next edge
//   at_max, at_zero  : count == N, count == 0
module nw_idx_counter
  import nw_pkg::*;
#(
  parameter int unsigned N = 128,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_next,
  output logic         at_max,
  output logic         at_zero
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max  = (cnt_q == W'(N));
  assign at_zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = at_max ? W'(1) : cnt_q + W'(1);
    end else if (dec) begin
      cnt_d = at_zero ? cnt_q : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= W'(IDX_SAFE);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;

endmodule

// File: rtl/nw_ab_index_gen.sv
// NW A/B sequence-RAM index generator. Owns counter i (sequence A) and
// counter j (sequence B); walks the row-major fill scan, then traceback
// driven by per-step move codes. All outputs are registered.
//   clk, rst       : clock, asynchronous active-low reset
//   start          : begin fill scan (from IDLE or END)
//   en_read        : fill-phase consume/advance
//   change_index   : hold request; blanks outputs, freezes counters/state
//   en_traceB      : enter/advance traceback
//   tb_step        : traceback move (TB_NONE/LEFT/UP/DIAG)
//   index_a/b      : A/B RAM addresses (0 when no valid access)
//   valid          : address(es) point at real characters
//   fill_done      : one-cycle pulse after (N,N) is consumed
//   tb_done        : level, traceback reached (0,0)
//   err            : sticky protocol error, only with NW_IDX_CHECK_EN defined
module nw_ab_index_gen
  import nw_pkg::*;
#(
  parameter int unsigned N       = 128,
  parameter int unsigned BitAddr = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en_read,
  input  logic             change_index,
  input  logic             en_traceB,
  input  logic [1:0]       tb_step,
  output logic [BitAddr:0] index_a,
  output logic [BitAddr:0] index_b,
  output logic             valid,
  output logic             fill_done,
  output logic             tb_done,
  output logic             err
);

  localparam int unsigned IW = BitAddr + 1;

  nw_idx_state_t state_q, state_d;

  logic          i_load, j_load, i_inc, j_inc, i_dec, j_dec;
  logic [IW-1:0] i_val, j_val, i_cnt, j_cnt, i_next, j_next;
  logic          i_max, j_max, i_zero, j_zero;
  logic          step_i, step_j;

  logic [IW-1:0] index_a_q, index_a_d, index_b_q, index_b_d;
  logic          valid_q, valid_d, fill_done_q, fill_done_d, tb_done_q, tb_done_d;

  assign step_i = (tb_step == TB_UP)   || (tb_step == TB_DIAG);
  assign step_j = (tb_step == TB_LEFT) || (tb_step == TB_DIAG);

  nw_idx_counter #(.N(N), .W(IW)) u_cnt_i (
    .clk      (clk),
    .rst_n    (rst),
    .load     (i_load),
    .load_val (i_val),
    .inc      (i_inc),
    .dec      (i_dec),
    .cnt      (i_cnt),
    .cnt_next (i_next),
    .at_max   (i_max),
    .at_zero  (i_zero)
  );

  nw_idx_counter #(.N(N), .W(IW)) u_cnt_j (
    .clk      (clk),
    .rst_n    (rst),
    .load     (j_load),
    .load_val (j_val),
    .inc      (j_inc),
    .dec      (j_dec),
    .cnt      (j_cnt),
    .cnt_next (j_next),
    .at_max   (j_max),
    .at_zero  (j_zero)
  );

  // Controller: change_index freezes everything by leaving all defaults.
  always_comb begin
    state_d     = state_q;
    i_load      = 1'b0;
    j_load      = 1'b0;
    i_val       = '0;
    j_val       = '0;
    i_inc       = 1'b0;
    j_inc       = 1'b0;
    i_dec       = 1'b0;
    j_dec       = 1'b0;
    fill_done_d = 1'b0;
    if (!change_index) begin
      unique case (state_q)
        ST_IDLE, ST_END: begin
          if (start) begin
            state_d = ST_FILL;
            i_load  = 1'b1;
            j_load  = 1'b1;
            i_val   = IW'(1);
            j_val   = IW'(1);
          end
        end
        ST_FILL: begin
          if (en_read) begin
            if (i_max && j_max) begin
              state_d     = ST_FILL_DONE;
              i_load      = 1'b1;
              j_load      = 1'b1;
              fill_done_d = 1'b1;
            end else begin
              j_inc = 1'b1;
              i_inc = j_max;
            end
          end
        end
        ST_FILL_DONE: begin
          if (en_traceB) begin
            state_d = ST_TRACE;
            i_load  = 1'b1;
            j_load  = 1'b1;
            i_val   = IW'(N);
            j_val   = IW'(N);
          end
        end
        ST_TRACE: begin
          if (en_traceB) begin
            i_dec = step_i;
            j_dec = step_j;
            // End test derived from current counts, not cnt_next, to keep
            // this block free of a feedback path through the counters.
            if ((i_zero || (step_i && i_cnt == IW'(1))) &&
                (j_zero || (step_j && j_cnt == IW'(1)))) begin
              state_d = ST_END;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are computed from the post-edge state/counter values so that
  // they register in the same edge as the update they reflect.
  always_comb begin
    index_a_d = IW'(IDX_SAFE);
    index_b_d = IW'(IDX_SAFE);
    valid_d   = 1'b0;
    tb_done_d = (state_d == ST_END);
    if (!change_index) begin
      if (state_d == ST_FILL) begin
        index_a_d = i_next;
        index_b_d = j_next;
        valid_d   = 1'b1;
      end else if (state_d == ST_TRACE) begin
        index_a_d = i_next;
        index_b_d = j_next;
        valid_d   = (i_next != '0) || (j_next != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      index_a_q   <= IW'(IDX_SAFE);
      index_b_q   <= IW'(IDX_SAFE);
      valid_q     <= 1'b0;
      fill_done_q <= 1'b0;
      tb_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_a_q   <= index_a_d;
      index_b_q   <= index_b_d;
      valid_q     <= valid_d;
      fill_done_q <= fill_done_d;
      tb_done_q   <= tb_done_d;
    end
  end

  assign index_a   = index_a_q;
  assign index_b   = index_b_q;
  assign valid     = valid_q;
  assign fill_done = fill_done_q;
  assign tb_done   = tb_done_q;

`ifdef NW_IDX_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start && !(state_q == ST_IDLE || state_q == ST_END)) begin
      err_d = 1'b1;
    end
    if (state_q == ST_TRACE) begin
      if (en_read) begin
        err_d = 1'b1;
      end
      if (en_traceB && !change_index &&
          ((step_i && i_zero) || (step_j && j_zero))) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nw_ab_index_gen.sv
module tb_nw_ab_index_gen;

  localparam logic [1:0] S_N = 2'b00;
  localparam logic [1:0] S_L = 2'b01;
  localparam logic [1:0] S_U = 2'b10;
  localparam logic [1:0] S_D = 2'b11;

`ifdef NW_IDX_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       v;
    logic       fd;
    logic       td;
    logic       er;
  } exp_t;

  typedef struct packed {
    logic       st;
    logic       rd;
    logic       ci;
    logic       tr;
    logic [1:0] stp;
    exp_t       e;
  } row_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, en_read, change_index, en_traceB;
  logic [1:0] tb_step;
  logic [3:0] index_a, index_b;
  logic       valid, fill_done, tb_done, err;

  exp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  nw_ab_index_gen #(.N(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .en_read      (en_read),
    .change_index (change_index),
    .en_traceB    (en_traceB),
    .tb_step      (tb_step),
    .index_a      (index_a),
    .index_b      (index_b),
    .valid        (valid),
    .fill_done    (fill_done),
    .tb_done      (tb_done),
    .err          (err)
  );

  function automatic exp_t ex(input int a, input int b, input logic v,
                              input logic fd, input logic td, input logic er);
    ex = {4'(a), 4'(b), v, fd, td, er};
  endfunction

  function automatic row_t mk(input logic st, input logic rd, input logic ci,
                              input logic tr, input logic [1:0] stp, input exp_t e);
    mk = {st, rd, ci, tr, stp, e};
  endfunction

  function automatic exp_t observed();
    observed = {index_a, index_b, valid, fill_done, tb_done, err};
  endfunction

  // Drive one cycle of stimulus, queue its expected registered result,
  // and return 1 time unit after the edge that registers it.
  task automatic apply(input row_t r);
    start        = r.st;
    en_read      = r.rd;
    change_index = r.ci;
    en_traceB    = r.tr;
    tb_step      = r.stp;
    sb.push_back(r.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    rst = 1'b0;
    start = 1'b0; en_read = 1'b0; change_index = 1'b0; en_traceB = 1'b0; tb_step = S_N;
    #12;
    sb.push_back(ex(0, 0, 0, 0, 0, 0));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset got=%03h need=%03h (a,b,v,fd,td,err)", o, e);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    apply(mk(0, 1, 0, 1, S_D, ex(0, 0, 0, 0, 0, 0)));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL idle_hold got=%03h need=%03h", o, e);
    end
  endtask

  task automatic test_fill();
    exp_t e, o;
    apply(mk(1, 1, 0, 0, S_N, ex(1, 1, 1, 0, 0, 0)));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL fill_start got=%03h need=%03h", o, e);
    end
    for (int k = 1; k <= 16; k++) begin
      if (k < 16) apply(mk(0, 1, 0, 0, S_N, ex(k / 4 + 1, k % 4 + 1, 1, 0, 0, 0)));
      else        apply(mk(0, 1, 0, 0, S_N, ex(0, 0, 0, 1, 0, 0)));
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fill[%0d] got=%03h need=%03h", k, o, e);
      end
    end
    for (int k = 0; k < 2; k++) begin
      apply(mk(0, 1, 0, 0, S_N, ex(0, 0, 0, 0, 0, 0)));
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fill_after[%0d] got=%03h need=%03h", k, o, e);
      end
    end
  endtask

  task automatic test_trace_diag();
    exp_t e, o;
    row_t rows[7];
    rows[0] = mk(0, 0, 0, 1, S_N, ex(4, 4, 1, 0, 0, 0));
    rows[1] = mk(0, 0, 0, 1, S_D, ex(3, 3, 1, 0, 0, 0));
    rows[2] = mk(0, 0, 0, 1, S_U, ex(2, 3, 1, 0, 0, 0));
    rows[3] = mk(0, 0, 0, 1, S_L, ex(2, 2, 1, 0, 0, 0));
    rows[4] = mk(0, 0, 0, 1, S_D, ex(1, 1, 1, 0, 0, 0));
    rows[5] = mk(0, 0, 0, 1, S_D, ex(0, 0, 0, 0, 1, 0));
    rows[6] = mk(0, 0, 0, 1, S_U, ex(0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 7; k++) begin
      apply(rows[k]);
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL trace_diag[%0d] got=%03h need=%03h", k, o, e);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e, o, x;
    int ei, ej;
    logic rd, ci, c1, c2, done;
    apply(mk(1, 0, 0, 0, S_N, ex(1, 1, 1, 0, 0, 0)));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL stall_start got=%03h need=%03h", o, e);
    end
    ei = 1; ej = 1; c1 = 1'b0; c2 = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      rd = (cyc % 2 == 0);
      ci = rd && ((ei == 2 && ej == 3 && !c1) || (ei == 4 && ej == 4 && !c2));
      if (ci) begin
        if (ei == 2) c1 = 1'b1; else c2 = 1'b1;
        x = ex(0, 0, 0, 0, 0, 0);
      end else if (rd) begin
        if (ei == 4 && ej == 4) begin
          done = 1'b1;
          x = ex(0, 0, 0, 1, 0, 0);
        end else begin
          if (ej == 4) begin ej = 1; ei++; end
          else ej++;
          x = ex(ei, ej, 1, 0, 0, 0);
        end
      end else begin
        x = ex(ei, ej, 1, 0, 0, 0);
      end
      apply(mk(0, rd, ci, 0, S_N, x));
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall[%0d] got=%03h need=%03h", cyc, o, e);
      end
    end
    if (!done || !c1 || !c2) begin
      errors++; checks++;
      $display("FAIL stall_scan_incomplete done=%b c1=%b c2=%b need all 1", done, c1, c2);
    end
  endtask

  task automatic test_trace_sat();
    exp_t e, o;
    row_t rows[11];
    rows[0]  = mk(0, 0, 0, 1, S_N, ex(4, 4, 1, 0, 0, 0));
    rows[1]  = mk(0, 0, 0, 1, S_L, ex(4, 3, 1, 0, 0, 0));
    rows[2]  = mk(0, 0, 0, 0, S_D, ex(4, 3, 1, 0, 0, 0));
    rows[3]  = mk(0, 0, 0, 1, S_L, ex(4, 2, 1, 0, 0, 0));
    rows[4]  = mk(0, 0, 1, 1, S_L, ex(0, 0, 0, 0, 0, 0));
    rows[5]  = mk(0, 0, 0, 1, S_L, ex(4, 1, 1, 0, 0, 0));
    rows[6]  = mk(0, 0, 0, 1, S_L, ex(4, 0, 1, 0, 0, 0));
    rows[7]  = mk(0, 0, 0, 1, S_U, ex(3, 0, 1, 0, 0, 0));
    rows[8]  = mk(0, 0, 0, 1, S_U, ex(2, 0, 1, 0, 0, 0));
    rows[9]  = mk(0, 0, 0, 1, S_U, ex(1, 0, 1, 0, 0, 0));
    rows[10] = mk(0, 0, 0, 1, S_U, ex(0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 11; k++) begin
      apply(rows[k]);
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL trace_sat[%0d] got=%03h need=%03h", k, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    apply(mk(1, 1, 0, 0, S_N, ex(1, 1, 1, 0, 0, 0)));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL mid_start got=%03h need=%03h", o, e);
    end
    for (int k = 1; k <= 9; k++) begin
      apply(mk(0, 1, 0, 0, S_N, ex(k / 4 + 1, k % 4 + 1, 1, 0, 0, 0)));
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mid_fill[%0d] got=%03h need=%03h", k, o, e);
      end
    end
    #2 rst = 1'b0;
    sb.push_back(ex(0, 0, 0, 0, 0, 0));
    #1;
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL mid_async_reset got=%03h need=%03h", o, e);
    end
    apply(mk(0, 1, 0, 0, S_N, ex(0, 0, 0, 0, 0, 0)));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL mid_in_reset got=%03h need=%03h", o, e);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    apply(mk(0, 1, 0, 0, S_N, ex(0, 0, 0, 0, 0, 0)));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL mid_idle got=%03h need=%03h", o, e);
    end
    apply(mk(1, 1, 0, 0, S_N, ex(1, 1, 1, 0, 0, 0)));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL mid_restart got=%03h need=%03h", o, e);
    end
    apply(mk(0, 1, 0, 0, S_N, ex(1, 2, 1, 0, 0, 0)));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL mid_next got=%03h need=%03h", o, e);
    end
  endtask

  task automatic test_err();
    exp_t e, o;
    apply(mk(1, 0, 0, 0, S_N, ex(1, 2, 1, 0, 0, ERR_EXP)));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL err_set got=%03h need=%03h", o, e);
    end
    for (int k = 0; k < 2; k++) begin
      apply(mk(0, 0, 0, 0, S_N, ex(1, 2, 1, 0, 0, ERR_EXP)));
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL err_sticky[%0d] got=%03h need=%03h", k, o, e);
      end
    end
    #2 rst = 1'b0;
    sb.push_back(ex(0, 0, 0, 0, 0, 0));
    #1;
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL err_cleared got=%03h need=%03h", o, e);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_trace_diag();
    test_stall();
    test_trace_sat();
    test_reset_mid();
    test_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t, need completion", $time);
    $fatal(1);
  end

endmodule
